// File: rtl/uart_rx_word_packer.sv
// uart_rx_word_packer: packs BYTES_PER_WORD received UART bytes into one word.
// An assembly register collects bytes. An output register presents finished
// words on a valid/ready interface, so the next word can be collected while
// the host stalls. A partial word is discarded after an inter-byte timeout.
// Bytes that arrive while a complete word is stalled are dropped and flagged
// on the sticky overrun_o output.
module uart_rx_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter bit BIG_ENDIAN     = 1'b0,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                        sourceClk,
  input  logic                        reset,
  input  logic [7:0]                  rx_byte,
  input  logic                        rx_complete,
  output logic [8*BYTES_PER_WORD-1:0] word_o,
  output logic                        word_valid_o,
  input  logic                        word_ready_i,
  output logic                        timeout_o,
  output logic                        overrun_o,
  input  logic                        overrun_clr_i,
  output logic                        busy_o
);

  localparam int W  = 8 * BYTES_PER_WORD;
  localparam int IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST_IDX   = IW'(BYTES_PER_WORD - 1);
  localparam logic [CW-1:0] EXPIRE_CNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {PkIdle, PkCollect, PkFull} pk_state_e;

  pk_state_e       state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    asm_q, asm_d;
  logic [W-1:0]    word_q, word_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;
  logic            overrun_q, overrun_d;

  logic            out_free;
  logic            word_done;
  logic [W-1:0]    done_word;

  // Writes byte number k of a word into its lane, honouring the byte order.
  function automatic logic [W-1:0] place_byte(input logic [W-1:0] w,
                                              input logic [IW-1:0] k,
                                              input logic [7:0] b);
    logic [W-1:0] r;
    int           lane;
    r    = w;
    lane = BIG_ENDIAN ? (BYTES_PER_WORD - 1 - int'(k)) : int'(k);
    r[lane*8 +: 8] = b;
    return r;
  endfunction

  // State and datapath registers; reset drops partial and pending words.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge sourceClk) begin
    if (!reset) begin
      state_q   <= PkIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      asm_q     <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic: byte collection, timeout, word hand-off and drops.
  always_comb begin
    // NOTE: every combinational output gets a default first, which rules out
    // inferred latches on paths that do not assign it.
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    word_d    = word_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    overrun_d = overrun_q;
    word_done = 1'b0;
    done_word = asm_q;

    // The output register can take a word if it is empty or drains this cycle.
    out_free = !valid_q || word_ready_i;

    if (valid_q && word_ready_i) begin
      valid_d = 1'b0;
      word_d  = '0;
    end

    // The clear comes first so that a drop in the same cycle wins.
    if (overrun_clr_i) overrun_d = 1'b0;

    unique case (state_q)
      PkIdle: begin
        if (rx_complete) begin
          done_word = place_byte('0, '0, rx_byte);
          asm_d     = done_word;
          cnt_d     = '0;
          if (BYTES_PER_WORD == 1) begin
            word_done = 1'b1;
          end else begin
            idx_d   = IW'(1);
            state_d = PkCollect;
          end
        end
      end
      PkCollect: begin
        if (rx_complete) begin
          done_word = place_byte(asm_q, idx_q, rx_byte);
          asm_d     = done_word;
          cnt_d     = '0;
          if (idx_q == LAST_IDX) word_done = 1'b1;
          else                   idx_d     = idx_q + IW'(1);
        end else if (cnt_q == EXPIRE_CNT) begin
          asm_d     = '0;
          idx_d     = '0;
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = PkIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PkFull: begin
        // A byte here is lost even if the held word moves out this cycle.
        if (rx_complete) overrun_d = 1'b1;
        if (out_free) begin
          word_d  = asm_q;
          valid_d = 1'b1;
          state_d = PkIdle;
        end
      end
      default: state_d = PkIdle;
    endcase

    // A finished word goes straight to the output register, or waits in PkFull.
    if (word_done) begin
      idx_d = '0;
      if (out_free) begin
        word_d  = done_word;
        valid_d = 1'b1;
        state_d = PkIdle;
      end else begin
        state_d = PkFull;
      end
    end
  end

  // Output logic: registered word, flags and the busy indication.
  always_comb begin
    word_o       = word_q;
    word_valid_o = valid_q;
    timeout_o    = timeout_q;
    overrun_o    = overrun_q;
    busy_o       = (state_q == PkCollect) || (state_q == PkFull);
  end

endmodule
